// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port memory between instruction fetch and load/store
module unified_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_mode,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_err,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);
    localparam int SW = $clog2(MAX_DSTREAK + 1);
    typedef enum logic [1:0] {IDLE, REQ, RESP} stateT;
    stateT state, stateNext;
    logic ownerD, killFlag, errPend, ifRvQ, dRvQ;
    logic arb, dWins, ifWins, dBad, start;
    logic [SW-1:0] streak;
    logic [2:0] mode;
    logic [1:0] lo;
    logic [31:0] rdQ, wdD, ext;
    logic [3:0] beD;
    logic [ADDR_W-1:0] selAddr;
    logic [7:0] byteSel;
    logic [15:0] halfSel;

    always_comb begin
        arb = state == IDLE && !errPend;
        dWins = arb && d_req && !(if_req && streak == SW'(MAX_DSTREAK));
        ifWins = arb && !dWins && if_req && !if_kill;
        dBad = d_mode == 3'b011 || d_mode[2:1] == 2'b11 || (d_mode[1:0] == 2'b01 && d_addr[0])
            || (d_mode[1:0] == 2'b10 && d_addr[1:0] != 2'b00);
        start = (dWins && !dBad) || ifWins;
        stateNext = state;
        case (state)
            IDLE: stateNext = start ? REQ : IDLE;
            REQ:  stateNext = mem_gnt ? (mem_we ? IDLE : RESP) : REQ;
            RESP: stateNext = mem_rvalid ? IDLE : RESP;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= stateNext;

    assign selAddr = dWins ? d_addr : if_addr;
    assign beD = !d_we ? 4'hF : d_mode[1:0] == 2'b00 ? 4'b0001 << d_addr[1:0]
               : d_mode[1:0] == 2'b01 ? 4'b0011 << {d_addr[1], 1'b0} : 4'hF;
    assign wdD = d_mode[1:0] == 2'b00 ? {4{d_wdata[7:0]}}
               : d_mode[1:0] == 2'b01 ? {2{d_wdata[15:0]}} : d_wdata;
    // lane select uses the byte offset captured at arbitration, not the live address
    assign byteSel = mem_rdata[{lo, 3'b000} +: 8];
    assign halfSel = lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    assign ext = mode[1:0] == 2'b00 ? {{24{~mode[2] & byteSel[7]}}, byteSel}
               : mode[1:0] == 2'b01 ? {{16{~mode[2] & halfSel[15]}}, halfSel} : mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ownerD <= 1'b0;
            killFlag <= 1'b0;
            errPend <= 1'b0;
            ifRvQ <= 1'b0;
            dRvQ <= 1'b0;
            streak <= '0;
            mode <= '0;
            lo <= '0;
            rdQ <= '0;
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_be <= '0;
            mem_wdata <= '0;
        end else begin
            ifRvQ <= 1'b0;
            dRvQ <= 1'b0;
            errPend <= dWins && dBad;
            if (arb)
                streak <= (!if_req || ifWins) ? '0
                        : (dWins && streak != SW'(MAX_DSTREAK)) ? streak + 1'b1 : streak;
            if (start) begin
                ownerD <= dWins;
                mem_req <= 1'b1;
                mem_we <= dWins && d_we;
                mem_addr <= selAddr & ~ADDR_W'(3);
                mem_be <= dWins ? beD : 4'hF;
                mem_wdata <= dWins ? wdD : '0;
                mode <= dWins ? d_mode : 3'b010;
                lo <= dWins ? d_addr[1:0] : 2'b00;
            end
            if (state == REQ && mem_gnt) mem_req <= 1'b0;
            if (state != IDLE && !ownerD && if_kill) killFlag <= 1'b1;
            // a kill arriving together with the read data still suppresses the response
            if (state == RESP && mem_rvalid) begin
                rdQ <= ext;
                ifRvQ <= !ownerD && !killFlag && !if_kill;
                dRvQ <= ownerD;
                killFlag <= 1'b0;
            end
        end
    end

    assign if_gnt = state == REQ && !ownerD && mem_gnt;
    assign d_gnt = (state == REQ && ownerD && mem_gnt) || errPend;
    assign d_err = errPend;
    assign if_rvalid = ifRvQ;
    assign d_rvalid = dRvQ;
    assign if_rdata = rdQ;
    assign d_rdata = rdQ;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: scoreboard bench with a zero-wait memory model and directed requests
module tb_unified_mem_arbiter;
    logic clk = 1'b0, rst_n = 1'b0;
    logic if_req = 1'b0, if_kill = 1'b0, if_gnt, if_rvalid;
    logic [31:0] if_addr = '0, if_rdata;
    logic d_req = 1'b0, d_we = 1'b0, d_gnt, d_err, d_rvalid;
    logic [2:0] d_mode = '0;
    logic [31:0] d_addr = '0, d_wdata = '0, d_rdata;
    logic mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0] mem_be;
    logic gntEn = 1'b1, rvEn = 1'b1, memRv;
    logic [31:0] memWord = '0;
    int tests = 0, fails = 0;
    typedef struct {int kind; logic [79:0] val;} evT;
    evT q[$];
    string kn[5] = '{"mem", "if_gnt", "d_gnt", "if_rvalid", "d_rvalid"};

    unified_mem_arbiter #(.ADDR_W(32), .MAX_DSTREAK(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_mode(d_mode), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_err(d_err), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    assign mem_gnt = mem_req && gntEn;
    assign mem_rvalid = memRv;
    assign mem_rdata = memWord;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) memRv <= 1'b0;
        else memRv <= mem_req && mem_gnt && !mem_we && rvEn;

    task automatic push(input int k, input logic [79:0] v);
        q.push_back('{kind: k, val: v});
    endtask

    task automatic observe(input int k, input logic [79:0] v);
        evT e;
        tests++;
        if (q.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected: got %s val=0x%0h, want nothing", kn[k], v);
        end else begin
            e = q.pop_front();
            if (e.kind != k || e.val !== v) begin
                fails++;
                $display("FAIL sb_%s: got %s val=0x%0h, want %s val=0x%0h", kn[e.kind], kn[k], v, kn[e.kind], e.val);
            end
        end
    endtask

    always @(negedge clk) if (rst_n) begin
        if (mem_req && mem_gnt) observe(0, 80'({mem_we, mem_be, mem_addr, mem_we ? mem_wdata : 32'h0}));
        if (if_gnt) observe(1, 80'(0));
        if (d_gnt) observe(2, 80'(d_err));
        if (if_rvalid) observe(3, 80'(if_rdata));
        if (d_rvalid) observe(4, 80'(d_rdata));
    end

    task automatic chk(input string n, input logic [79:0] act, input logic [79:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", n, act, want);
        end
    endtask

    task automatic chkRst(input string n);
        chk({n, "_mem"}, 80'({mem_req, mem_we, mem_be, mem_addr, mem_wdata}), 80'(0));
        chk({n, "_gnt"}, 80'({if_gnt, d_gnt, d_err}), 80'(0));
        chk({n, "_rvalid"}, 80'({if_rvalid, d_rvalid}), 80'(0));
        chk({n, "_rdata"}, 80'({if_rdata, d_rdata}), 80'(0));
    endtask

    task automatic waitFor(input int sel, input int first, input int lim, output int cyc);
        logic s;
        cyc = -1;
        for (int c = first; c < first + lim; c++) begin
            @(negedge clk);
            s = sel == 0 ? if_gnt : sel == 1 ? d_gnt : sel == 2 ? if_rvalid : d_rvalid;
            if (s) begin
                cyc = c;
                break;
            end
        end
        if (cyc < 0) begin
            tests++;
            fails++;
            $display("FAIL timeout: got no event sel=%0d, want one within %0d cycles", sel, lim);
        end
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] w, input bit kill, output int g, output int r);
        push(0, 80'({1'b0, 4'hF, a, 32'h0}));
        push(1, 80'(0));
        if (!kill) push(3, 80'(w));
        memWord = w;
        @(posedge clk) #1;
        if_req = 1'b1;
        if_addr = a;
        waitFor(0, 0, 40, g);
        @(posedge clk) #1;
        if_req = 1'b0;
        if_kill = kill;
        r = -1;
        if (kill) begin
            @(posedge clk) #1;
            if_kill = 1'b0;
            repeat (3) @(posedge clk);
        end else waitFor(2, g + 1, 40, r);
    endtask

    task automatic dReq(input logic we, input logic [2:0] m, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] eBe, input logic [31:0] eWd, input logic [31:0] eRd,
                        input bit bad, output int g, output int r);
        if (bad) push(2, 80'(1));
        else begin
            push(0, 80'({we, eBe, a & ~32'h3, we ? eWd : 32'h0}));
            push(2, 80'(0));
            if (!we) push(4, 80'(eRd));
        end
        @(posedge clk) #1;
        d_req = 1'b1;
        d_we = we;
        d_mode = m;
        d_addr = a;
        d_wdata = wd;
        waitFor(1, 0, 40, g);
        @(posedge clk) #1;
        d_req = 1'b0;
        r = -1;
        if (!bad && !we) waitFor(3, g + 1, 40, r);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g, r, gi;
        #3 chkRst("reset");
        @(negedge clk) rst_n = 1'b1;
        fetch(32'h40, 32'h00500093, 0, g, r);
        chk("fetch_gnt_cycle", 80'(g), 80'(1));
        chk("fetch_rvalid_cycle", 80'(r), 80'(3));
        gntEn = 1'b0;
        fork
            dReq(1'b1, 3'b000, 32'h103, 32'hAB, 4'b1000, 32'hABABABAB, 32'h0, 0, g, r);
            begin
                repeat (3) @(posedge clk);
                #1 chk("stall_hold", 80'({mem_req, mem_be, mem_addr}), 80'({1'b1, 4'b1000, 32'h100}));
                gntEn = 1'b1;
            end
        join
        dReq(1'b1, 3'b001, 32'h102, 32'h1234, 4'b1100, 32'h12341234, 32'h0, 0, g, r);
        dReq(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 32'h0, 0, g, r);
        memWord = 32'h80FF7F01;
        dReq(1'b0, 3'b000, 32'h203, 32'h0, 4'hF, 32'h0, 32'hFFFFFF80, 0, g, r);
        chk("load_rvalid_cycle", 80'(r), 80'(3));
        dReq(1'b0, 3'b100, 32'h203, 32'h0, 4'hF, 32'h0, 32'h00000080, 0, g, r);
        dReq(1'b0, 3'b001, 32'h202, 32'h0, 4'hF, 32'h0, 32'hFFFF80FF, 0, g, r);
        dReq(1'b0, 3'b101, 32'h202, 32'h0, 4'hF, 32'h0, 32'h000080FF, 0, g, r);
        dReq(1'b0, 3'b000, 32'h201, 32'h0, 4'hF, 32'h0, 32'h0000007F, 0, g, r);
        dReq(1'b0, 3'b001, 32'h200, 32'h0, 4'hF, 32'h0, 32'h00007F01, 0, g, r);
        dReq(1'b0, 3'b010, 32'h200, 32'h0, 4'hF, 32'h0, 32'h80FF7F01, 0, g, r);
        dReq(1'b0, 3'b010, 32'h201, 32'h0, 4'hF, 32'h0, 32'h0, 1, g, r);
        chk("misaligned_gnt_cycle", 80'(g), 80'(1));
        dReq(1'b0, 3'b001, 32'h203, 32'h0, 4'hF, 32'h0, 32'h0, 1, g, r);
        dReq(1'b0, 3'b011, 32'h200, 32'h0, 4'hF, 32'h0, 32'h0, 1, g, r);
        dReq(1'b1, 3'b010, 32'h102, 32'h5, 4'hF, 32'h0, 32'h0, 1, g, r);
        // starvation: four data grants, then the waiting fetch, then the remaining six stores
        memWord = 32'hCAFE0013;
        for (int i = 0; i < 4; i++) begin
            push(0, 80'({1'b1, 4'hF, 32'h300 + 32'(4 * i), 32'(i)}));
            push(2, 80'(0));
        end
        push(0, 80'({1'b0, 4'hF, 32'h44, 32'h0}));
        push(1, 80'(0));
        push(3, 80'(32'hCAFE0013));
        for (int i = 4; i < 10; i++) begin
            push(0, 80'({1'b1, 4'hF, 32'h300 + 32'(4 * i), 32'(i)}));
            push(2, 80'(0));
        end
        @(posedge clk) #1;
        fork
            begin
                if_req = 1'b1;
                if_addr = 32'h44;
                waitFor(0, 0, 100, gi);
                @(posedge clk) #1 if_req = 1'b0;
            end
            begin
                d_req = 1'b1;
                d_we = 1'b1;
                d_mode = 3'b010;
                for (int i = 0; i < 10; i++) begin
                    int gd;
                    d_addr = 32'h300 + 32'(4 * i);
                    d_wdata = 32'(i);
                    waitFor(1, 0, 100, gd);
                    @(posedge clk) #1;
                end
                d_req = 1'b0;
            end
        join
        repeat (4) @(posedge clk);
        fetch(32'h80, 32'h11111111, 1, g, r);
        memWord = 32'h80FF7F01;
        dReq(1'b0, 3'b010, 32'h200, 32'h0, 4'hF, 32'h0, 32'h80FF7F01, 0, g, r);
        fetch(32'h84, 32'h00000013, 0, g, r);
        chk("post_kill_rvalid_cycle", 80'(r), 80'(3));
        push(0, 80'({1'b0, 4'hF, 32'h48, 32'h0}));
        push(1, 80'(0));
        rvEn = 1'b0;
        @(posedge clk) #1;
        if_req = 1'b1;
        if_addr = 32'h48;
        waitFor(0, 0, 40, g);
        @(posedge clk) #1 if_req = 1'b0;
        #2 rst_n = 1'b0;
        #1 chkRst("resp_reset");
        @(negedge clk) rst_n = 1'b1;
        rvEn = 1'b1;
        fetch(32'h0, 32'h00100073, 0, g, r);
        chk("reset_recover_rvalid_cycle", 80'(r), 80'(3));
        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 80'(q.size()), 80'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
